// File: rtl/lifo_pkg.sv
// lifo_pkg
//   Shared definitions for the LIFO stack slice.
//   - WIDTH_DEF / AW_DEF : default data width and pointer width.
//   - op_e               : push/pop request encoding, {Push, Pop}.
package lifo_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned AW_DEF    = 5;

  // Built as {Push, Pop}. SWAP is a simultaneous push and pop.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_SWAP = 2'b11
  } op_e;

endpackage

// File: rtl/lifo_stack_ptr.sv
// stack_ptr
//   Saturating up/down occupancy counter for the LIFO stack.
//   Ports:
//     clk_i   : rising-edge clock
//     rst_ni  : synchronous active-low clear
//     en_i    : count enable
//     up_i    : direction, 1 = increment, 0 = decrement
//     count_o : occupancy, 0..2**AW (AW+1 bits)
//     full_o  : count_o == 2**AW
//     empty_o : count_o == 0
module stack_ptr
  import lifo_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        up_i,
  output logic [AW:0] count_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  logic [AW:0] count_q, count_d;

  // Saturates at both ends, so a stray request never wraps the pointer.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      if (up_i && !full_o) begin
        count_d = count_q + ONE;
      end else if (!up_i && !empty_o) begin
        count_d = count_q - ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == DEPTH);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/lifo_stack.sv
// lifo_stack
//   Register-file LIFO with a registered, one-cycle-latency pop port.
//   Ports:
//     Clk        : rising-edge clock
//     Rst_n      : synchronous active-low reset
//     Push       : push request, Din written this cycle
//     Pop        : pop request, top entry returned next cycle on Dout
//     Din        : push data
//     Dout       : popped data (registered, holds between pops)
//     Dout_Valid : one-cycle strobe qualifying Dout
//     Full       : Count == 2**AW
//     Empty      : Count == 0
//     Count      : occupancy 0..2**AW
//     Err_Ovf    : sticky, push attempted while Full
//     Err_Udf    : sticky, pop attempted while Empty
//   Push+Pop on a non-empty stack replaces the top entry (legal when Full);
//   Push+Pop on an empty stack passes Din straight to Dout.
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Push,
  input  logic             Pop,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic             Dout_Valid,
  output logic             Full,
  output logic             Empty,
  output logic [AW:0]      Count,
  output logic             Err_Ovf,
  output logic             Err_Udf
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             ptr_en;
  logic             ptr_up;

  logic [AW:0]      top_ptr;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  op_e              op;

  stack_ptr #(
    .AW (AW)
  ) u_stack_ptr (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .en_i    (ptr_en),
    .up_i    (ptr_up),
    .count_o (Count),
    .full_o  (Full),
    .empty_o (Empty)
  );

  // Top entry lives at mem[SP-1]; the next free slot is mem[SP]. The
  // truncated indices are only used when the matching Empty/Full guard
  // rules out the wrapped value.
  assign top_ptr = Count - ONE;
  assign top_idx = top_ptr[AW-1:0];
  assign wr_idx  = Count[AW-1:0];
  assign op      = op_e'({Push, Pop});

  always_comb begin
    dout_d    = dout_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    mem_wdata = Din;
    ptr_en    = 1'b0;
    ptr_up    = 1'b0;

    unique case (op)
      OP_IDLE: begin
      end
      OP_POP: begin
        if (!Empty) begin
          dout_d  = mem_q[top_idx];
          valid_d = 1'b1;
          ptr_en  = 1'b1;
        end else begin
          udf_d = 1'b1;
        end
      end
      OP_PUSH: begin
        if (!Full) begin
          mem_we = 1'b1;
          ptr_en = 1'b1;
          ptr_up = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      OP_SWAP: begin
        valid_d = 1'b1;
        if (!Empty) begin
          dout_d    = mem_q[top_idx];
          mem_we    = 1'b1;
          mem_waddr = top_idx;
        end else begin
          dout_d = Din;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (mem_we && Rst_n) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign Dout       = dout_q;
  assign Dout_Valid = valid_q;
  assign Err_Ovf    = ovf_q;
  assign Err_Udf    = udf_q;

endmodule
